// File: rtl/aes_cbc_decrypt_ctrl_if.sv
// Stream, core and status signals of the CBC decrypt sequencer.
// master = fabric/core side, slave = controller side.
interface aes_cbc_decrypt_ctrl_if;
  logic         iv_load;
  logic [127:0] iv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_ct;
  logic         core_load;
  logic [127:0] core_ct;
  logic [127:0] core_pt;
  logic         core_valid;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_pt;
  logic         busy;
  logic         err;

  modport master (
    output iv_load, iv, in_valid, in_ct, core_pt, core_valid, out_ready,
    input  in_ready, core_load, core_ct, out_valid, out_pt, busy, err
  );

  modport slave (
    input  iv_load, iv, in_valid, in_ct, core_pt, core_valid, out_ready,
    output in_ready, core_load, core_ct, out_valid, out_pt, busy, err
  );
endinterface

// File: rtl/aes_cbc_decrypt_ctrl.sv
// CBC-mode sequencer for one aes_decrypt core: one block in flight, plaintext = core_pt ^ chain.
// Optional core watchdog enabled by defining AES_CBC_DEC_WDOG_EN.
module aes_cbc_decrypt_ctrl #(
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  aes_cbc_decrypt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t       state;
  logic [127:0] chain_q;
  logic [127:0] ct_q;
  logic [127:0] pt_q;
  logic         idle_q;
  logic         load_q;
  logic         ov_q;
  logic         iv_acc;
  logic         in_hs;
  logic         timeout;

  // idle_q mirrors state==IDLE but is 0 during reset so in_ready stays low there
  assign iv_acc       = (state == IDLE) & bus.iv_load;
  assign bus.in_ready = idle_q & ~bus.iv_load;
  assign in_hs        = bus.in_valid & bus.in_ready;

  assign bus.core_load = load_q;
  assign bus.core_ct   = ct_q;
  assign bus.out_valid = ov_q;
  assign bus.out_pt    = pt_q;
  assign bus.busy      = (state != IDLE);

`ifdef AES_CBC_DEC_WDOG_EN
  localparam int unsigned CW = $clog2(TMO_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          err_q;

  assign timeout = (wd_cnt == CW'(TMO_CYCLES - 1));
  assign bus.err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == ISSUE)
        wd_cnt <= '0;
      else if (state == WAIT)
        wd_cnt <= wd_cnt + CW'(1);
      if (iv_acc)
        err_q <= 1'b0;
      else if (state == WAIT && !bus.core_valid && timeout)
        err_q <= 1'b1;
    end
  end
`else
  logic tmo_unused;

  assign tmo_unused = (TMO_CYCLES != 0);
  assign timeout    = 1'b0;
  assign bus.err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      chain_q <= '0;
      ct_q    <= '0;
      pt_q    <= '0;
      idle_q  <= 1'b0;
      load_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state)
        IDLE: begin
          if (iv_acc)
            chain_q <= bus.iv;
          if (in_hs) begin
            ct_q   <= bus.in_ct;
            state  <= ISSUE;
            idle_q <= 1'b0;
            load_q <= 1'b1;
          end else begin
            idle_q <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // completion has priority over a coincident timeout
          if (bus.core_valid) begin
            pt_q    <= bus.core_pt ^ chain_q;
            chain_q <= ct_q;
            ov_q    <= 1'b1;
            state   <= OUT;
          end else if (timeout) begin
            state  <= IDLE;
            idle_q <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            ov_q   <= 1'b0;
            state  <= IDLE;
            idle_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_decrypt_ctrl.sv
// Scoreboard bench for aes_cbc_decrypt_ctrl with a behavioural stand-in for the AES core.
module tb_aes_cbc_decrypt_ctrl;

  localparam logic [127:0] IV1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  // raw AES-128 decryptions (key 2b7e1516...) of CT1 and CT2
  localparam logic [127:0] D1  = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] D2  = 128'hd86421fb9f1a1eda505ee1375746972c;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_cbc_decrypt_ctrl_if bus();

  aes_cbc_decrypt_ctrl #(.TMO_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int vcyc = 0;
  int n_hs = 0;
  int n_load_cyc = 0;
  int n_out = 0;
  int rst_epoch = 0;
  int lat_fix = 0;
  logic stub_dead = 1'b0;
  logic stub_valid = 1'b0;
  logic spur_valid = 1'b0;
  logic [127:0] stub_pt = '0;
  logic [1:0] rdy_mode = 2'd1;
  logic rnd_bit = 1'b0;
  logic [127:0] chain_m = '0;
  logic [127:0] last_pt = '0;

  logic [127:0] exp_q[$];
  logic [127:0] ct_iss_q[$];
  int           hs_q[$];

  assign bus.core_valid = stub_valid | spur_valid;
  assign bus.core_pt    = stub_pt;
  assign bus.out_ready  = (rdy_mode == 2'd2) ? rnd_bit : rdy_mode[0];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Stand-in for AES decryption: the two known vectors, otherwise a fixed bijection
  function automatic logic [127:0] core_fn(input logic [127:0] c);
    if (c == CT1) return D1;
    if (c == CT2) return D2;
    return {c[63:0], c[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got timeout/none expected event", name);
  endtask

  // Core stub: responds L cycles after core_load, abandons the block across a reset
  int s_ep;
  int s_lat;
  logic [127:0] s_ct;
  always begin
    @(posedge clk);
    if (rst_n && bus.core_load) begin
      if (hs_q.size() == 0) tmo("unexpected_load");
      else begin
        check("load_cycle", 128'(cyc), 128'(hs_q.pop_front() + 1));
        check("core_ct", bus.core_ct, ct_iss_q.pop_front());
      end
      s_ct  = bus.core_ct;
      s_ep  = rst_epoch;
      s_lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 4));
      if (!stub_dead) begin
        repeat (s_lat - 1) @(posedge clk);
        if (s_ep == rst_epoch) begin
          #1;
          stub_pt    = core_fn(s_ct);
          stub_valid = 1'b1;
          vcyc       = cyc;
          @(posedge clk);
          #1 stub_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake
  logic ov_prev = 1'b0;
  logic hs_prev = 1'b0;
  logic [127:0] pt_prev = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
      hs_prev <= 1'b0;
    end else begin
      if (bus.out_valid && ov_prev && !hs_prev) check("out_hold", bus.out_pt, pt_prev);
      if (bus.out_valid && !ov_prev) check("out_latency", 128'(cyc), 128'(vcyc + 1));
      if (bus.core_load) n_load_cyc++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) tmo("unexpected_out");
        else check("out_pt", bus.out_pt, exp_q.pop_front());
        last_pt <= bus.out_pt;
        n_out++;
      end
      ov_prev <= bus.out_valid;
      hs_prev <= bus.out_valid && bus.out_ready;
      pt_prev <= bus.out_pt;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake
  task automatic send(input logic [127:0] ct, input bit expect_out);
    int g;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_ct    = ct;
    @(negedge clk);
    while (!bus.in_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) tmo("send_accept");
    else begin
      hs_q.push_back(cyc);
      ct_iss_q.push_back(ct);
      if (expect_out) begin
        exp_q.push_back(core_fn(ct) ^ chain_m);
        chain_m = ct;
      end
      n_hs++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_ct    = rnd128();
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy || exp_q.size() != 0) tmo(name);
  endtask

  task automatic load_iv(input logic [127:0] v);
    wait_idle("iv_wait_idle");
    @(posedge clk);
    #1;
    bus.iv_load = 1'b1;
    bus.iv      = v;
    @(posedge clk);
    #1;
    bus.iv_load = 1'b0;
    bus.iv      = rnd128();
    chain_m     = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(bus.in_ready), '0);
    check({tag, "_core_load"}, 128'(bus.core_load), '0);
    check({tag, "_out_valid"}, 128'(bus.out_valid), '0);
    check({tag, "_busy"}, 128'(bus.busy), '0);
    check({tag, "_err"}, 128'(bus.err), '0);
    check({tag, "_out_pt"}, bus.out_pt, '0);
    check({tag, "_core_ct"}, bus.core_ct, '0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    int hs;
    int n_out_save;
    logic [127:0] r;
    bus.iv_load  = 1'b0;
    bus.iv       = '0;
    bus.in_valid = 1'b0;
    bus.in_ct    = '0;

    #12;
    check_zero_outputs("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic decrypt and chaining with known vectors
    load_iv(IV1);
    send(CT1, 1'b1);
    wait_idle("tv1_drain");
    check("tv1_pt", last_pt, PT1);
    check("tv1_single_load", 128'(n_load_cyc), 128'(n_hs));
    @(posedge clk);
    #1;
    send(CT2, 1'b1);
    wait_idle("tv2_drain");
    check("tv2_pt", last_pt, PT2);

    // output backpressure
    @(posedge clk);
    #1 rdy_mode = 2'd0;
    send(rnd128(), 1'b1);
    g = 0;
    while (!bus.out_valid && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_valid) tmo("bp_out_valid");
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 128'(bus.in_ready), '0);
      check("bp_core_load", 128'(bus.core_load), '0);
    end
    @(posedge clk);
    #1 rdy_mode = 2'd1;
    @(negedge clk);
    @(negedge clk);
    check("bp_busy_after", 128'(bus.busy), '0);
    check("bp_ready_after", 128'(bus.in_ready), 128'(1));
    @(posedge clk);
    #1;

    // IV load collides with data: IV wins, block taken next cycle
    r = rnd128();
    bus.iv_load  = 1'b1;
    bus.iv       = IV1 ^ 128'h1;
    bus.in_valid = 1'b1;
    bus.in_ct    = r;
    @(negedge clk);
    check("iv_collide_ready", 128'(bus.in_ready), '0);
    @(posedge clk);
    #1;
    bus.iv_load = 1'b0;
    chain_m     = IV1 ^ 128'h1;
    check("iv_collide_busy", 128'(bus.busy), '0);
    send(r, 1'b1);
    wait_idle("collide_drain");

    // spurious core_valid in IDLE
    @(posedge clk);
    #1 spur_valid = 1'b1;
    @(posedge clk);
    #1 spur_valid = 1'b0;
    @(negedge clk);
    check("spur_busy", 128'(bus.busy), '0);
    @(posedge clk);
    #1;
    send(rnd128(), 1'b1);
    wait_idle("spur_drain");

    // reset during WAIT
    @(posedge clk);
    #1 lat_fix = 6;
    send(rnd128(), 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wait_busy", 128'(bus.busy), 128'(1));
    n_out_save = n_out;
    rst_n = 1'b0;
    rst_epoch++;
    exp_q.delete();
    hs_q.delete();
    ct_iss_q.delete();
    chain_m = '0;
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    lat_fix = 0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_output", 128'(n_out), 128'(n_out_save));
    send(rnd128(), 1'b1);
    wait_idle("rst_chain0_drain");
    load_iv(IV1);
    send(CT1, 1'b1);
    wait_idle("rst_tv1_drain");
    check("rst_tv1_pt", last_pt, PT1);

    // randomized traffic with random backpressure and IV reloads
    @(posedge clk);
    #1 rdy_mode = 2'd2;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) load_iv(rnd128());
      send(rnd128(), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle("rand_drain");
    @(posedge clk);
    #1 rdy_mode = 2'd1;

`ifdef AES_CBC_DEC_WDOG_EN
    // watchdog: core never answers
    stub_dead = 1'b1;
    send(rnd128(), 1'b0);
    hs = hs_q.size() > 0 ? cyc : cyc;
    hs = cyc - 1;
    g = 0;
    @(negedge clk);
    while (bus.busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) tmo("wdog_return");
    check("wdog_cycles", 128'(cyc), 128'(hs + 10));
    check("wdog_err", 128'(bus.err), 128'(1));
    stub_dead = 1'b0;
    @(posedge clk);
    #1;
    send(rnd128(), 1'b1);
    wait_idle("wdog_chain_drain");
    check("wdog_err_sticky", 128'(bus.err), 128'(1));
    load_iv(rnd128());
    @(negedge clk);
    check("wdog_err_clear", 128'(bus.err), '0);
`else
    check("err_tied", 128'(bus.err), '0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("load_count", 128'(n_load_cyc), 128'(n_hs));
    check("queue_empty", 128'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
